// File: rtl/stack_pkg.sv
// Shared types and defaults for the parameterised LIFO stack.
// Holds the op encoding, default sizes and the stack_ctrl control enums.
package stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    PUSH = 3'd1,
    POP  = 3'd2,
    TOS  = 3'd3,
    DUP  = 3'd4,
    SWAP = 3'd5,
    REPL = 3'd6,
    CLR  = 3'd7
  } op_t;

  // d_out next-value source
  typedef enum logic [2:0] {
    DS_HOLD,
    DS_DIN,
    DS_TOP,
    DS_NOS,
    DS_ZERO
  } dsel_t;

  // array write pattern
  typedef enum logic [2:0] {
    WS_NONE,
    WS_PUSH,
    WS_DUP,
    WS_REPL,
    WS_SWAP
  } wsel_t;

  // stack pointer update
  typedef enum logic [1:0] {
    SP_HOLD,
    SP_INC,
    SP_DEC,
    SP_CLR
  } spd_t;

endpackage

// File: rtl/stack_ctrl.sv
// Op decoder: turns op plus occupancy into datapath controls and error sets.
// In: op, empty, full, has_two. Out: accept, wsel, spd, dsel, set_ovf, set_udf.
module stack_ctrl
  import stack_pkg::*;
(
  input  op_t   op,
  input  logic  empty,
  input  logic  full,
  input  logic  has_two,
  output logic  accept,
  output wsel_t wsel,
  output spd_t  spd,
  output dsel_t dsel,
  output logic  set_ovf,
  output logic  set_udf
);

  always_comb begin
    accept  = 1'b0;
    wsel    = WS_NONE;
    spd     = SP_HOLD;
    dsel    = DS_HOLD;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    unique case (op)
      NOP: ;
      PUSH: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          accept = 1'b1;
          wsel   = WS_PUSH;
          spd    = SP_INC;
          dsel   = DS_DIN;
        end
      end
      POP: begin
        if (empty) begin
          set_udf = 1'b1;
        end else begin
          accept = 1'b1;
          spd    = SP_DEC;
          dsel   = has_two ? DS_NOS : DS_ZERO;
        end
      end
      TOS: begin
        accept = 1'b1;
        dsel   = empty ? DS_ZERO : DS_TOP;
      end
      DUP: begin
        if (empty) begin
          set_udf = 1'b1;
        end else if (full) begin
          set_ovf = 1'b1;
        end else begin
          accept = 1'b1;
          wsel   = WS_DUP;
          spd    = SP_INC;
          dsel   = DS_TOP;
        end
      end
      SWAP: begin
        if (!has_two) begin
          set_udf = 1'b1;
        end else begin
          accept = 1'b1;
          wsel   = WS_SWAP;
          dsel   = DS_NOS;
        end
      end
      REPL: begin
        if (empty) begin
          set_udf = 1'b1;
        end else begin
          accept = 1'b1;
          wsel   = WS_REPL;
          dsel   = DS_DIN;
        end
      end
      CLR: begin
        accept = 1'b1;
        spd    = SP_CLR;
        dsel   = DS_ZERO;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_stack.sv
// Register-array LIFO stack with registered top view and sticky error flags.
// Ports: clk, rst, op, d_in, err_clr -> d_out, empty, full, count, ovf, udf.
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           d_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    a_sp;
  logic [AW-1:0]    a_top;
  logic [AW-1:0]    a_nos;
  logic [WIDTH-1:0] top_v;
  logic [WIDTH-1:0] nos_v;
  logic             has_two;

  logic  accept;
  wsel_t wsel;
  spd_t  spd;
  dsel_t dsel;
  logic  set_ovf;
  logic  set_udf;

  // DEPTH is a power of two, so modulo-DEPTH index math is exact;
  // sp == DEPTH maps a_sp to 0 and a_top to DEPTH-1.
  assign a_sp    = sp[AW-1:0];
  assign a_top   = a_sp - AW'(1);
  assign a_nos   = a_sp - AW'(2);
  assign top_v   = mem[a_top];
  assign nos_v   = mem[a_nos];

  assign empty   = (sp == '0);
  assign full    = (sp == CW'(DEPTH));
  assign has_two = (sp >= CW'(2));
  assign count   = sp;

  stack_ctrl u_ctrl (
    .op      (op_t'(op)),
    .empty   (empty),
    .full    (full),
    .has_two (has_two),
    .accept  (accept),
    .wsel    (wsel),
    .spd     (spd),
    .dsel    (dsel),
    .set_ovf (set_ovf),
    .set_udf (set_udf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      d_out <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= set_ovf | (ovf & ~err_clr);
      udf <= set_udf | (udf & ~err_clr);
      if (accept) begin
        unique case (spd)
          SP_INC:  sp <= sp + CW'(1);
          SP_DEC:  sp <= sp - CW'(1);
          SP_CLR:  sp <= '0;
          default: ;
        endcase
        unique case (dsel)
          DS_DIN:  d_out <= d_in;
          DS_TOP:  d_out <= top_v;
          DS_NOS:  d_out <= nos_v;
          DS_ZERO: d_out <= '0;
          default: ;
        endcase
      end
    end
  end

  // Array is deliberately not reset; a write racing a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      unique case (wsel)
        WS_PUSH: mem[a_sp]  <= d_in;
        WS_DUP:  mem[a_sp]  <= top_v;
        WS_REPL: mem[a_top] <= d_in;
        WS_SWAP: begin
          mem[a_top] <= nos_v;
          mem[a_nos] <= top_v;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack at WIDTH=8, DEPTH=4.
// Reference model predicts outputs; directed checks pin the key vectors.
module tb_param_stack;
  import stack_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    string      tag;
    logic [7:0] d;
    int         cnt;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  op_t        op = NOP;
  logic [7:0] d_in = '0;
  logic       err_clr = 1'b0;
  logic [7:0] d_out;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       ovf;
  logic       udf;

  int n_vec = 0;
  int n_bad = 0;

  exp_t sb[$];

  logic [7:0] m_mem [D];
  int         m_cnt = 0;
  logic [7:0] m_d = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  param_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .d_in    (d_in),
    .err_clr (err_clr),
    .d_out   (d_out),
    .empty   (empty),
    .full    (full),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    m_cnt = 0;
    m_d   = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model(input op_t o, input logic [7:0] v, input logic c);
    logic [7:0] t;
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    case (o)
      PUSH: if (m_cnt == D) m_ovf = 1'b1;
            else begin m_mem[m_cnt] = v; m_cnt++; m_d = v; end
      POP:  if (m_cnt == 0) m_udf = 1'b1;
            else begin
              m_d = (m_cnt >= 2) ? m_mem[m_cnt-2] : 8'h00;
              m_cnt--;
            end
      TOS:  m_d = (m_cnt == 0) ? 8'h00 : m_mem[m_cnt-1];
      DUP:  if (m_cnt == 0) m_udf = 1'b1;
            else if (m_cnt == D) m_ovf = 1'b1;
            else begin
              m_d = m_mem[m_cnt-1];
              m_mem[m_cnt] = m_d;
              m_cnt++;
            end
      SWAP: if (m_cnt < 2) m_udf = 1'b1;
            else begin
              t = m_mem[m_cnt-1];
              m_mem[m_cnt-1] = m_mem[m_cnt-2];
              m_mem[m_cnt-2] = t;
              m_d = m_mem[m_cnt-1];
            end
      REPL: if (m_cnt == 0) m_udf = 1'b1;
            else begin m_mem[m_cnt-1] = v; m_d = v; end
      CLR:  begin m_cnt = 0; m_d = 8'h00; end
      default: ;
    endcase
  endtask

  task automatic step(input op_t o, input logic [7:0] v, input logic c,
                      input string tag);
    exp_t e;
    @(negedge clk);
    op      = o;
    d_in    = v;
    err_clr = c;
    model(o, v, c);
    e.tag = tag;
    e.d   = m_d;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    e.udf = m_udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    op      = NOP;
    err_clr = 1'b0;
    e = sb.pop_front();
    chk({e.tag, ".d"}, 32'(d_out), 32'(e.d));
    chk({e.tag, ".cnt"}, 32'(count), 32'(e.cnt));
    chk({e.tag, ".emp"}, 32'(empty), 32'(e.cnt == 0));
    chk({e.tag, ".full"}, 32'(full), 32'(e.cnt == D));
    chk({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
    chk({e.tag, ".udf"}, 32'(udf), 32'(e.udf));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.d", 32'(d_out), 32'h0);
    chk("rst.cnt", 32'(count), 32'd0);
    chk("rst.emp", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    chk("rst.udf", 32'(udf), 32'd0);

    step(PUSH, 8'h11, 1'b0, "push1");
    step(PUSH, 8'h22, 1'b0, "push2");
    step(PUSH, 8'h33, 1'b0, "push3");
    chk("p3.cnt", 32'(count), 32'd3);
    chk("p3.d", 32'(d_out), 32'h33);
    step(PUSH, 8'h44, 1'b0, "push4");
    step(PUSH, 8'h55, 1'b0, "pushf");
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.d", 32'(d_out), 32'h44);
    chk("ovf.flag", 32'(ovf), 32'd1);
    step(POP, 8'h00, 1'b0, "pop1");
    chk("pop1.d", 32'(d_out), 32'h33);
    step(POP, 8'h00, 1'b0, "pop2");
    chk("pop2.d", 32'(d_out), 32'h22);
    step(POP, 8'h00, 1'b0, "pop3");
    chk("pop3.d", 32'(d_out), 32'h11);
    step(POP, 8'h00, 1'b0, "pop4");
    chk("pop4.d", 32'(d_out), 32'h00);
    chk("pop4.emp", 32'(empty), 32'd1);
    step(NOP, 8'h00, 1'b1, "clr_ovf");

    step(PUSH, 8'h11, 1'b0, "s.p1");
    step(PUSH, 8'h22, 1'b0, "s.p2");
    step(SWAP, 8'h00, 1'b0, "swap");
    chk("swap.d", 32'(d_out), 32'h11);
    step(POP, 8'h00, 1'b0, "s.pop");
    chk("s.pop.d", 32'(d_out), 32'h22);
    step(DUP, 8'h00, 1'b0, "dup");
    chk("dup.cnt", 32'(count), 32'd2);
    chk("dup.d", 32'(d_out), 32'h22);
    step(NOP, 8'h00, 1'b0, "nop");
    step(CLR, 8'h00, 1'b0, "clr");

    step(POP, 8'h00, 1'b0, "udf.pop");
    chk("udf.flag", 32'(udf), 32'd1);
    chk("udf.d", 32'(d_out), 32'h00);
    step(POP, 8'h00, 1'b1, "udf.race");
    chk("udf.race", 32'(udf), 32'd1);
    step(NOP, 8'h00, 1'b1, "udf.clr");
    chk("udf.clr", 32'(udf), 32'd0);

    step(PUSH, 8'hAA, 1'b0, "r.push");
    step(REPL, 8'h5A, 1'b0, "repl");
    chk("repl.d", 32'(d_out), 32'h5A);
    chk("repl.cnt", 32'(count), 32'd1);
    step(SWAP, 8'h00, 1'b0, "swap1");
    step(CLR, 8'h00, 1'b0, "clr2");
    chk("clr2.cnt", 32'(count), 32'd0);
    chk("clr2.udf", 32'(udf), 32'd1);
    step(DUP, 8'h00, 1'b0, "dup.e");
    step(REPL, 8'h77, 1'b0, "repl.e");
    step(TOS, 8'h00, 1'b0, "tos.e");
    step(NOP, 8'h00, 1'b1, "clr3");
    for (int i = 0; i < 5; i++) step(DUP, 8'h00, 1'b0, "dupf");
    step(PUSH, 8'h01, 1'b0, "dupf.p");
    for (int i = 0; i < 4; i++) step(DUP, 8'h00, 1'b0, "dupf2");
    step(TOS, 8'h00, 1'b0, "tos.f");

    for (int i = 0; i < 300; i++)
      step(op_t'($urandom_range(7)), 8'($urandom),
           ($urandom_range(7) == 0), "rnd");

    step(CLR, 8'h00, 1'b1, "pre.ar");
    step(PUSH, 8'hC1, 1'b0, "ar.p1");
    step(PUSH, 8'hC2, 1'b0, "ar.p2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_rst();
    #1;
    chk("ar.cnt", 32'(count), 32'd0);
    chk("ar.d", 32'(d_out), 32'h00);
    chk("ar.emp", 32'(empty), 32'd1);
    chk("ar.full", 32'(full), 32'd0);
    #1;
    rst = 1'b0;
    step(TOS, 8'h00, 1'b0, "ar.tos");
    chk("ar.tos.d", 32'(d_out), 32'h00);
    step(PUSH, 8'hE5, 1'b0, "ar.push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 16: entry count, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 op  input  3  operation code, sampled every cycle: NOP, PUSH, POP, TOS, DUP, SWAP, REPL, CLR.
REQ-006 d_in  input  WIDTH  operand for PUSH and REPL.
REQ-007 err_clr  input  1  clears the sticky error flags.
REQ-008 d_out  output  WIDTH  registered top-of-stack view.
REQ-009 empty  output  1  count == 0, combinational from the stack pointer.
REQ-010 full  output  1  count == DEPTH, combinational from the stack pointer.
REQ-011 count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 udf  output  1  sticky underflow flag.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH register array with stack pointer sp = count, where top = mem[sp-1] and next-of-stack (NOS) = mem[sp-2].
REQ-015 PUSH when not full SHALL write d_in to mem[sp] and increment sp; d_out <= d_in at the same edge.
REQ-016 POP when not empty SHALL decrement sp; d_out <= old NOS when old count >= 2, else 0.
REQ-017 TOS SHALL leave the stack unchanged and set d_out <= top (0 if empty).
REQ-018 DUP when 1 <= count < DEPTH SHALL write top to mem[sp] and increment sp; d_out <= top.
REQ-019 SWAP when count >= 2 SHALL exchange top and NOS in one cycle; d_out <= old NOS.
REQ-020 REPL when not empty SHALL overwrite top with d_in, with sp unchanged; d_out <= d_in.
REQ-021 CLR SHALL set sp = 0 and d_out = 0, and SHALL NOT modify ovf or udf.
REQ-022 NOP SHALL hold all state, including d_out.
REQ-023 Rejected ops SHALL leave sp, mem and d_out unchanged:
- PUSH or DUP when full: set ovf.
- POP, DUP, REPL or TOS-free underflow when empty: set udf.
- SWAP when count < 2: set udf.
REQ-024 All op effects SHALL be visible on outputs one cycle after the sampling edge; there is no multi-cycle operation and no busy state.
REQ-025 ovf and udf SHALL remain set until err_clr; if err_clr and a new error occur in the same cycle, the flag SHALL end set.
REQ-026 sp arithmetic SHALL saturate at 0 and DEPTH by rule, never wrapping.

Reset
REQ-027 On rst assertion, regardless of clk, the block SHALL set sp = 0, d_out = 0, ovf = 0 and udf = 0, so that empty = 1, full = 0 and count = 0.
REQ-028 Array contents SHALL NOT be reset; no output SHALL expose an unwritten entry.
REQ-029 Reset asserted mid-operation SHALL abort that op; the first op after rst deassertion SHALL be sampled on the next rising edge.

Structure
REQ-030 A shared package stack_pkg SHALL hold the op_t enum:
- NOP=0, PUSH=1, POP=2, TOS=3, DUP=4, SWAP=5, REPL=6, CLR=7.
REQ-031 stack_pkg SHALL also hold the default WIDTH and DEPTH constants.
REQ-032 One sub-module, stack_ctrl, SHALL decode op, count and flags into the accept, write-enable, sp-delta and d_out-select controls; the datapath SHALL stay in param_stack.

Verification (WIDTH=8, DEPTH=4)
REQ-033 Reset, then PUSH 0x11, 0x22, 0x33 -> count=3, d_out=0x33, empty=0, full=0.
REQ-034 From count=3: PUSH 0x44, then PUSH 0x55 -> full=1, count=4, d_out=0x44, ovf=1; POP x4 -> d_out shows 0x33, 0x22, 0x11, 0x00 in turn, then empty=1.
REQ-035 Stack {0x11, 0x22}: SWAP -> d_out=0x11, then POP -> d_out=0x22; DUP -> count=2, d_out=0x22.
REQ-036 Empty stack: POP -> udf=1, d_out=0; same-cycle err_clr plus POP -> udf stays 1; err_clr alone -> udf=0.
REQ-037 Stack {0xAA}: REPL 0x5A -> d_out=0x5A, count=1; CLR -> count=0, d_out=0, ovf and udf unchanged.
REQ-038 Assert rst asynchronously between clock edges with count=2 -> outputs reach reset values before the next edge; TOS afterwards -> d_out=0.
